// File: rtl/race_turn_controller.sv
// rtl/race_turn_controller.sv - dice-race turn, token stepping and winner detection
//
// Purpose: sits after the die-colour result stage. It takes a die roll (1..3 steps),
// walks the current player's token forward one square every STEP_TICKS cycles, rotates
// turns when the die is removed, and detects the winner at the goal square.
//
// Optional feature macro: RACE_BOUNCE_EN
//   undefined : token clamps at GOAL, first arrival at GOAL wins.
//   defined   : exact landing required; steps beyond GOAL bounce back down the board.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-low reset
//   game_start     in   1-cycle pulse, (re)starts the game; highest priority
//   result_ready   in   1-cycle pulse, new die result available
//   movement_steps in   [1:0] steps to move, 0 means no move
//   turn_end       in   1-cycle pulse, die removed from view
//   cur_player     out  [1:0] player whose turn it is
//   pos_flat       out  packed positions, player p at [p*POS_W +: POS_W]
//   busy           out  high while a move is in progress
//   step_pulse     out  1-cycle pulse on each token step
//   game_over      out  high once a winner is found
//   winner         out  [1:0] winning player, valid with game_over
//   fsm_state      out  [2:0] IDLE=0 WAIT_ROLL=1 MOVE=2 WAIT_CLEAR=3 DONE=4

module race_turn_controller #(
    parameter int NUM_PLAYERS = 2,
    parameter int BOARD_LEN   = 20,
    parameter int STEP_TICKS  = 12_500_000,
    parameter int POS_W       = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         game_start,
    input  logic                         result_ready,
    input  logic [1:0]                   movement_steps,
    input  logic                         turn_end,
    output logic [1:0]                   cur_player,
    output logic [NUM_PLAYERS*POS_W-1:0] pos_flat,
    output logic                         busy,
    output logic                         step_pulse,
    output logic                         game_over,
    output logic [1:0]                   winner,
    output logic [2:0]                   fsm_state
);

    localparam int                TICK_W      = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(STEP_TICKS - 1);
    localparam logic [POS_W-1:0]  GOAL        = POS_W'(BOARD_LEN - 1);
    localparam logic [1:0]        LAST_PLAYER = 2'(NUM_PLAYERS - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_ROLL  = 3'd1,
        MOVE       = 3'd2,
        WAIT_CLEAR = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t                       state_q, state_d;
    logic [1:0]                   steps_q, steps_d;
    logic [TICK_W-1:0]            tick_q, tick_d;
    logic [1:0]                   cur_d;
    logic [NUM_PLAYERS*POS_W-1:0] pos_d;
    logic                         busy_d, step_d, game_over_d;
    logic [1:0]                   winner_d;
    logic [POS_W-1:0]             pos_cur, pos_step;
    logic                         goal_win;
`ifdef RACE_BOUNCE_EN
    // 1 = token is walking back down the board for the rest of this move
    logic                         dir_q, dir_d, dir_next;
`endif

    assign fsm_state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            steps_q    <= '0;
            tick_q     <= '0;
            cur_player <= '0;
            pos_flat   <= '0;
            busy       <= 1'b0;
            step_pulse <= 1'b0;
            game_over  <= 1'b0;
            winner     <= '0;
`ifdef RACE_BOUNCE_EN
            dir_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            steps_q    <= steps_d;
            tick_q     <= tick_d;
            cur_player <= cur_d;
            pos_flat   <= pos_d;
            busy       <= busy_d;
            step_pulse <= step_d;
            game_over  <= game_over_d;
            winner     <= winner_d;
`ifdef RACE_BOUNCE_EN
            dir_q      <= dir_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        steps_d     = steps_q;
        tick_d      = tick_q;
        cur_d       = cur_player;
        pos_d       = pos_flat;
        step_d      = 1'b0;
        game_over_d = game_over;
        winner_d    = winner;
        pos_cur     = '0;

        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (cur_player == 2'(p)) begin
                pos_cur = pos_flat[p*POS_W +: POS_W];
            end
        end

`ifdef RACE_BOUNCE_EN
        dir_d    = dir_q;
        // Stepping off GOAL while steps remain turns the token around.
        dir_next = dir_q | (pos_cur == GOAL);
        if (dir_next) begin
            pos_step = (pos_cur == '0) ? pos_cur : pos_cur - 1'b1;
        end else begin
            pos_step = pos_cur + 1'b1;
        end
        goal_win = (pos_cur == GOAL) && (steps_q == 2'd0);
`else
        pos_step = (pos_cur == GOAL) ? pos_cur : pos_cur + 1'b1;
        goal_win = (pos_cur == GOAL);
`endif

        if (game_start) begin
            state_d     = WAIT_ROLL;
            steps_d     = '0;
            tick_d      = '0;
            cur_d       = '0;
            pos_d       = '0;
            game_over_d = 1'b0;
`ifdef RACE_BOUNCE_EN
            dir_d       = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: ;
                WAIT_ROLL: begin
                    if (result_ready && (movement_steps != 2'd0)) begin
                        state_d = MOVE;
                        steps_d = movement_steps;
                        tick_d  = '0;
`ifdef RACE_BOUNCE_EN
                        dir_d   = 1'b0;
`endif
                    end
                end
                MOVE: begin
                    // Win/finish are evaluated the cycle after a step, so the
                    // final step_pulse is always visible before the state changes.
                    if (goal_win) begin
                        state_d     = DONE;
                        steps_d     = '0;
                        game_over_d = 1'b1;
                        winner_d    = cur_player;
                    end else if (steps_q == 2'd0) begin
                        state_d = WAIT_CLEAR;
                    end else if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        steps_d = steps_q - 2'd1;
                        step_d  = 1'b1;
`ifdef RACE_BOUNCE_EN
                        dir_d   = dir_next;
`endif
                        for (int p = 0; p < NUM_PLAYERS; p++) begin
                            if (cur_player == 2'(p)) begin
                                pos_d[p*POS_W +: POS_W] = pos_step;
                            end
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                WAIT_CLEAR: begin
                    if (turn_end) begin
                        state_d = WAIT_ROLL;
                        cur_d   = (cur_player == LAST_PLAYER) ? 2'd0 : cur_player + 2'd1;
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == MOVE);
    end

endmodule

// File: tb/tb_race_turn_controller.sv
// tb/tb_race_turn_controller.sv - directed self-checking bench for race_turn_controller

module tb_race_turn_controller;

    localparam int NP = 3;
    localparam int BL = 8;
    localparam int ST = 4;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          game_start = 1'b0;
    logic          result_ready = 1'b0;
    logic [1:0]    movement_steps = 2'd0;
    logic          turn_end = 1'b0;
    logic [1:0]    cur_player;
    logic [NP*PW-1:0] pos_flat;
    logic          busy;
    logic          step_pulse;
    logic          game_over;
    logic [1:0]    winner;
    logic [2:0]    fsm_state;

    int vectors = 0;
    int miscompares = 0;
    int pulses;

    race_turn_controller #(
        .NUM_PLAYERS(NP),
        .BOARD_LEN  (BL),
        .STEP_TICKS (ST),
        .POS_W      (PW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .game_start    (game_start),
        .result_ready  (result_ready),
        .movement_steps(movement_steps),
        .turn_end      (turn_end),
        .cur_player    (cur_player),
        .pos_flat      (pos_flat),
        .busy          (busy),
        .step_pulse    (step_pulse),
        .game_over     (game_over),
        .winner        (winner),
        .fsm_state     (fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pos_of(input int p);
        return pos_flat[p*PW +: PW];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(fsm_state), 32'd0);
        chk({tag, "_pos"}, 32'(pos_flat), 32'd0);
        chk({tag, "_cur"}, 32'(cur_player), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_step"}, 32'(step_pulse), 32'd0);
        chk({tag, "_over"}, 32'(game_over), 32'd0);
        chk({tag, "_winner"}, 32'(winner), 32'd0);
    endtask

    // Accept a roll, run the move to its end (bounded), check pulse count and end state.
    task automatic roll(input logic [1:0] s, input int exp_pulses, input logic [2:0] exp_state);
        int n;
        int cycles;
        movement_steps = s;
        result_ready   = 1'b1;
        cyc();
        result_ready   = 1'b0;
        movement_steps = 2'd0;
        n = 0;
        cycles = 0;
        while (fsm_state == 3'd2 && cycles < 100) begin
            cyc();
            cycles++;
            if (step_pulse) n++;
        end
        chk("roll_bound", 32'(cycles < 100), 32'd1);
        chk("roll_pulses", 32'(n), 32'(exp_pulses));
        chk("roll_state", 32'(fsm_state), 32'(exp_state));
    endtask

    task automatic end_turn(input logic [1:0] exp_cur);
        turn_end = 1'b1;
        cyc();
        turn_end = 1'b0;
        chk("turn_state", 32'(fsm_state), 32'd1);
        chk("turn_cur", 32'(cur_player), 32'(exp_cur));
    endtask

    initial begin
        // reset state, IDLE ignores rolls
        repeat (3) cyc();
        chk_reset_vals("rst");
        reset = 1'b1;
        movement_steps = 2'd2;
        result_ready = 1'b1;
        cyc();
        result_ready = 1'b0;
        chk("idle_ignore", 32'(fsm_state), 32'd0);

        // T1 reset mid-move
        game_start = 1'b1;
        cyc();
        game_start = 1'b0;
        chk("t1_start", 32'(fsm_state), 32'd1);
        movement_steps = 2'd3;
        result_ready = 1'b1;
        cyc();
        result_ready = 1'b0;
        chk("t1_move", 32'(fsm_state), 32'd2);
        chk("t1_busy", 32'(busy), 32'd1);
        repeat (6) cyc();
        chk("t1_pos_before", 32'(pos_of(0)), 32'd1);
        reset = 1'b0;
        #1;
        chk_reset_vals("t1_rst");
        pulses = 0;
        repeat (6) begin
            cyc();
            if (step_pulse) pulses++;
        end
        reset = 1'b1;
        repeat (10) begin
            cyc();
            if (step_pulse) pulses++;
        end
        chk("t1_no_pulse", 32'(pulses), 32'd0);
        chk("t1_idle", 32'(fsm_state), 32'd0);
        chk("t1_pos_after", 32'(pos_flat), 32'd0);

        // T2 basic turn
        game_start = 1'b1;
        cyc();
        game_start = 1'b0;
        movement_steps = 2'd2;
        result_ready = 1'b1;
        cyc();
        result_ready = 1'b0;
        chk("t2_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk($sformatf("t2_step_%0d", k), 32'(step_pulse), 32'((k == 4) || (k == 8)));
        end
        chk("t2_pos0", 32'(pos_of(0)), 32'd2);
        cyc();
        chk("t2_wclear", 32'(fsm_state), 32'd3);
        chk("t2_busy_low", 32'(busy), 32'd0);
        end_turn(2'd1);
        // turn_end in WAIT_ROLL is ignored
        end_turn(2'd1);

        // T3 steps=0 and pulses during MOVE
        movement_steps = 2'd0;
        result_ready = 1'b1;
        cyc();
        result_ready = 1'b0;
        chk("t3_zero_state", 32'(fsm_state), 32'd1);
        chk("t3_zero_busy", 32'(busy), 32'd0);
        movement_steps = 2'd2;
        result_ready = 1'b1;
        cyc();
        result_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 2) begin
                movement_steps = 2'd3;
                result_ready = 1'b1;
                turn_end = 1'b1;
            end
            cyc();
            result_ready = 1'b0;
            turn_end = 1'b0;
            chk($sformatf("t3_step_%0d", k), 32'(step_pulse), 32'((k == 4) || (k == 8)));
        end
        chk("t3_pos1", 32'(pos_of(1)), 32'd2);
        chk("t3_pos0", 32'(pos_of(0)), 32'd2);
        cyc();
        chk("t3_wclear", 32'(fsm_state), 32'd3);
        chk("t3_cur", 32'(cur_player), 32'd1);

        // T4 wrap and collision
        end_turn(2'd2);
        roll(2'd1, 1, 3'd3);
        chk("t4_pos2", 32'(pos_of(2)), 32'd1);
        turn_end = 1'b1;
        result_ready = 1'b1;
        movement_steps = 2'd3;
        cyc();
        turn_end = 1'b0;
        result_ready = 1'b0;
        chk("t4_cur_wrap", 32'(cur_player), 32'd0);
        chk("t4_state", 32'(fsm_state), 32'd1);
        cyc();
        chk("t4_no_move", 32'(fsm_state), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);

        // T5 bring P0 to square 6, then roll 3
        roll(2'd3, 3, 3'd3);
        end_turn(2'd1);
        roll(2'd1, 1, 3'd3);
        end_turn(2'd2);
        roll(2'd1, 1, 3'd3);
        end_turn(2'd0);
        roll(2'd1, 1, 3'd3);
        end_turn(2'd1);
        roll(2'd1, 1, 3'd3);
        end_turn(2'd2);
        roll(2'd1, 1, 3'd3);
        end_turn(2'd0);
        chk("t5_pre", 32'(pos_flat), 32'({3'd3, 3'd4, 3'd6}));
`ifdef RACE_BOUNCE_EN
        roll(2'd3, 3, 3'd3);
        chk("t5_bounce_pos", 32'(pos_of(0)), 32'd5);
        chk("t5_bounce_over", 32'(game_over), 32'd0);
`else
        roll(2'd3, 1, 3'd4);
        chk("t5_pos", 32'(pos_of(0)), 32'd7);
        chk("t5_over", 32'(game_over), 32'd1);
        chk("t5_winner", 32'(winner), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        turn_end = 1'b1;
        result_ready = 1'b1;
        movement_steps = 2'd1;
        cyc();
        turn_end = 1'b0;
        result_ready = 1'b0;
        cyc();
        chk("t5_done_hold", 32'(fsm_state), 32'd4);
        chk("t5_done_pos", 32'(pos_of(0)), 32'd7);
`endif

        // T6 restart
        game_start = 1'b1;
        cyc();
        game_start = 1'b0;
        chk("t6_pos", 32'(pos_flat), 32'd0);
        chk("t6_cur", 32'(cur_player), 32'd0);
        chk("t6_over", 32'(game_over), 32'd0);
        chk("t6_state", 32'(fsm_state), 32'd1);

`ifdef RACE_BOUNCE_EN
        // exact landing from square 4 with a roll of 3
        roll(2'd3, 3, 3'd3);
        end_turn(2'd1);
        roll(2'd1, 1, 3'd3);
        end_turn(2'd2);
        roll(2'd1, 1, 3'd3);
        end_turn(2'd0);
        roll(2'd1, 1, 3'd3);
        end_turn(2'd1);
        roll(2'd1, 1, 3'd3);
        end_turn(2'd2);
        roll(2'd1, 1, 3'd3);
        end_turn(2'd0);
        chk("t5b_pre", 32'(pos_of(0)), 32'd4);
        roll(2'd3, 3, 3'd4);
        chk("t5b_pos", 32'(pos_of(0)), 32'd7);
        chk("t5b_over", 32'(game_over), 32'd1);
        chk("t5b_winner", 32'(winner), 32'd0);
        game_start = 1'b1;
        cyc();
        game_start = 1'b0;
`endif

        // game_start overrides a move in progress
        movement_steps = 2'd3;
        result_ready = 1'b1;
        cyc();
        result_ready = 1'b0;
        repeat (2) cyc();
        game_start = 1'b1;
        cyc();
        game_start = 1'b0;
        chk("gs_state", 32'(fsm_state), 32'd1);
        chk("gs_busy", 32'(busy), 32'd0);
        pulses = 0;
        repeat (8) begin
            cyc();
            if (step_pulse) pulses++;
        end
        chk("gs_no_pulse", 32'(pulses), 32'd0);
        chk("gs_pos", 32'(pos_flat), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
